int_ctrl: RTL and testbench

// - Memory-mapped interrupt controller between the six hardware interrupt sources (Timer0 IRQ, Timer1 IRQ,

---
 rtl/int_ctrl.sv | 107 ++++++++++
 tb/tb_int_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: edge/level latching, masks, priority status for HWInt.
// Optional software FORCE register is enabled by defining INTC_FORCE_EN.
module int_ctrl #(
    parameter int NSRC     = 6,
    parameter bit PRIO_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [29:0]     Addr,
    input  logic            SEL,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] irq_in,
    output logic [NSRC-1:0] HWInt
);

    logic            gen;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pend_nxt;
    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] set_vec;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] req;
    logic [2:0]      stat_idx;
    logic            stat_vld;
    logic            wr;
    logic [2:0]      off;
    logic            unused_ok;

    assign unused_ok = ^{Addr[29:3], Din[31:NSRC]};

    assign off      = Addr[2:0];
    assign wr       = SEL & WE;
    assign edge_det = irq_in & ~irq_q;
    assign w1c      = (wr && off == 3'd3) ? Din[NSRC-1:0] : '0;

`ifdef INTC_FORCE_EN
    logic [NSRC-1:0] force_set;
    assign force_set = (wr && off == 3'd5) ? Din[NSRC-1:0] : '0;
    assign set_vec   = edge_det | force_set;
`else
    assign set_vec   = edge_det;
`endif

    // Edge sources hold until W1C (set wins); level sources track irq_in.
    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (mode[i])
                pend_nxt[i] = set_vec[i] | (pend[i] & ~w1c[i]);
            else
                pend_nxt[i] = irq_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gen   <= 1'b0;
            mask  <= '0;
            mode  <= '0;
            pend  <= '0;
            irq_q <= '0;
        end else begin
            irq_q <= irq_in;
            pend  <= pend_nxt;
            if (wr && off == 3'd0) gen  <= Din[0];
            if (wr && off == 3'd1) mask <= Din[NSRC-1:0];
            if (wr && off == 3'd2) mode <= Din[NSRC-1:0];
        end
    end

    assign req   = pend & mask;
    assign HWInt = req & {NSRC{gen}};

    // Later loop iterations overwrite earlier ones, so the last index wins.
    always_comb begin
        stat_vld = 1'b0;
        stat_idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            int j;
            j = PRIO_LOW ? (NSRC - 1 - i) : i;
            if (req[j]) begin
                stat_vld = 1'b1;
                stat_idx = 3'(j);
            end
        end
    end

    always_comb begin
        Dout = '0;
        if (SEL && !WE) begin
            case (off)
                3'd0:    Dout = {31'b0, gen};
                3'd1:    Dout = {{(32-NSRC){1'b0}}, mask};
                3'd2:    Dout = {{(32-NSRC){1'b0}}, mode};
                3'd3:    Dout = {{(32-NSRC){1'b0}}, pend};
                3'd4:    Dout = {stat_vld, 28'b0, stat_idx};
                default: Dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        SEL;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  irq_in;
    logic [5:0]  HWInt;

    int tests = 0;
    int fails = 0;

    int_ctrl #(.NSRC(6), .PRIO_LOW(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .SEL    (SEL),
        .WE     (WE),
        .Din    (Din),
        .Dout   (Dout),
        .irq_in (irq_in),
        .HWInt  (HWInt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        SEL  = 1'b1;
        WE   = 1'b1;
        Addr = {27'b0, a};
        Din  = d;
        tick();
        SEL  = 1'b0;
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        SEL  = 1'b1;
        WE   = 1'b0;
        Addr = {27'b0, a};
        #1;
        d    = Dout;
        SEL  = 1'b0;
        #1;
    endtask

    logic [31:0] r;

    initial begin
        reset  = 1'b1;
        Addr   = '0;
        SEL    = 1'b0;
        WE     = 1'b0;
        Din    = '0;
        irq_in = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_hwint", {26'b0, HWInt}, 32'h0);
        chk("rst_dout_nosel", Dout, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), r);
            chk($sformatf("rst_reg%0d", a), r, 32'h0);
        end

        // Edge mode pulse
        wr(3'd0, 32'h1);
        wr(3'd1, 32'h3F);
        wr(3'd2, 32'h3F);
        irq_in = 6'h02;
        tick();
        irq_in = 6'h00;
        chk("edge_hwint", {26'b0, HWInt}, 32'h02);
        rd(3'd3, r);
        chk("edge_pend", r, 32'h02);
        tick();
        chk("edge_hold", {26'b0, HWInt}, 32'h02);
        wr(3'd3, 32'h02);
        chk("edge_w1c", {26'b0, HWInt}, 32'h00);

        // Level mode, W1C ignored
        wr(3'd2, 32'h00);
        wr(3'd1, 32'h04);
        irq_in = 6'h04;
        tick();
        chk("lvl_c1", {26'b0, HWInt}, 32'h04);
        tick();
        chk("lvl_c2", {26'b0, HWInt}, 32'h04);
        wr(3'd3, 32'h04);
        chk("lvl_w1c", {26'b0, HWInt}, 32'h04);
        tick();
        chk("lvl_c4", {26'b0, HWInt}, 32'h04);
        tick();
        chk("lvl_c5", {26'b0, HWInt}, 32'h04);
        irq_in = 6'h00;
        tick();
        chk("lvl_drop", {26'b0, HWInt}, 32'h00);

        // Priority encode
        wr(3'd2, 32'h3F);
        wr(3'd1, 32'h3F);
        irq_in = 6'h09;
        tick();
        irq_in = 6'h00;
        rd(3'd3, r);
        chk("prio_pend", r, 32'h09);
        rd(3'd4, r);
        chk("prio_stat0", r, 32'h80000000);
        wr(3'd3, 32'h01);
        rd(3'd4, r);
        chk("prio_stat3", r, 32'h80000003);
        chk("prio_hwint", {26'b0, HWInt}, 32'h08);
        wr(3'd3, 32'h08);
        rd(3'd4, r);
        chk("prio_none", r, 32'h00000000);

        // Set beats W1C, mask and global enable
        wr(3'd1, 32'h00);
        irq_in = 6'h10;
        wr(3'd3, 32'h10);
        irq_in = 6'h00;
        rd(3'd3, r);
        chk("setwin_pend", r, 32'h10);
        chk("masked_hwint", {26'b0, HWInt}, 32'h00);
        wr(3'd1, 32'h10);
        chk("unmask_hwint", {26'b0, HWInt}, 32'h10);
        wr(3'd0, 32'h0);
        chk("gen_off_hwint", {26'b0, HWInt}, 32'h00);
        rd(3'd4, r);
        chk("stat_no_gen", r, 32'h80000004);
        wr(3'd4, 32'hFFFFFFFF);
        rd(3'd4, r);
        chk("stat_ro", r, 32'h80000004);
        SEL  = 1'b0;
        WE   = 1'b1;
        Addr = 30'd1;
        Din  = 32'h0;
        tick();
        WE   = 1'b0;
        rd(3'd1, r);
        chk("nosel_wr", r, 32'h10);

        // FORCE register
        wr(3'd5, 32'h20);
        rd(3'd3, r);
`ifdef INTC_FORCE_EN
        chk("force_pend", r, 32'h30);
`else
        chk("noforce_pend", r, 32'h10);
`endif
        rd(3'd5, r);
        chk("off5_rd", r, 32'h0);

        // Reset with pending state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_hwint", {26'b0, HWInt}, 32'h0);
        rd(3'd3, r);
        chk("rst2_pend", r, 32'h0);
        rd(3'd1, r);
        chk("rst2_mask", r, 32'h0);
        rd(3'd4, r);
        chk("rst2_stat", r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
